// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings and state type for the elevator controller
package elevator_pkg;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;

  localparam logic [1:0] DOOR_HOLD  = 2'b00;
  localparam logic [1:0] DOOR_OPEN  = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;

  localparam logic [1:0] SD_TRANSIT = 2'b00;
  localparam logic [1:0] SD_OPEN    = 2'b01;
  localparam logic [1:0] SD_CLOSED  = 2'b10;
  localparam logic [1:0] SD_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLOSING,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_OPENING,
    ST_DWELL,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/elevator_ctrl_request_scan.sv
// rtl/elevator_ctrl_request_scan.sv - classifies pending calls relative to the current floor
module request_scan #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3
) (
  input  logic [BUTTONS_WIDTH-1:0] pending,
  input  logic [FLOOR_WIDTH-1:0]   floor,
  output logic                     req_here,
  output logic                     req_above,
  output logic                     req_below
);

  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (pending[i]) begin
        if (i == int'(floor))     req_here  = 1'b1;
        else if (i > int'(floor)) req_above = 1'b1;
        else                      req_below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - collective (SCAN) cabin controller with door/engine watchdog
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH  = 8,
  parameter int FLOOR_WIDTH    = 3,
  parameter int DWELL_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] buttons,
  input  logic [1:0]               sensor_door,
  input  logic                     sensor_up,
  input  logic                     sensor_down,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic [FLOOR_WIDTH-1:0]   floor,
  output logic [BUTTONS_WIDTH-1:0] pending,
  output logic                     fault
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DWELL_W-1:0]     DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [WD_W-1:0]        WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR  = FLOOR_WIDTH'(BUTTONS_WIDTH - 1);

  state_t                   state;
  logic                     dir_up;
  logic [DWELL_W-1:0]       dwell_cnt;
  logic [WD_W-1:0]          wd_cnt;
  logic                     req_here, req_above, req_below;
  logic                     moving, timed, floor_pulse, stop_next, go_up, fault_now;
  logic [FLOOR_WIDTH-1:0]   next_floor;
  logic [BUTTONS_WIDTH-1:0] served, next_pending;

  request_scan #(
    .BUTTONS_WIDTH(BUTTONS_WIDTH),
    .FLOOR_WIDTH  (FLOOR_WIDTH)
  ) u_scan (
    .pending  (pending),
    .floor    (floor),
    .req_here (req_here),
    .req_above(req_above),
    .req_below(req_below)
  );

  always_comb begin
    moving      = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
    timed       = moving || (state == ST_CLOSING) || (state == ST_OPENING);
    floor_pulse = ((state == ST_MOVE_UP) && sensor_up) || ((state == ST_MOVE_DOWN) && sensor_down);
    next_floor  = (state == ST_MOVE_UP) ? floor + FLOOR_WIDTH'(1) : floor - FLOOR_WIDTH'(1);
    stop_next   = floor_pulse && pending[next_floor];
    // Keep sweeping in the current direction while calls remain ahead.
    go_up       = req_above && (dir_up || !req_below);
    fault_now   = (sensor_door == SD_INVALID)
               || (sensor_up && (floor == TOP_FLOOR))
               || (sensor_down && (floor == '0))
               || (moving && (sensor_door != SD_CLOSED))
               || ((state == ST_MOVE_UP) && sensor_down)
               || ((state == ST_MOVE_DOWN) && sensor_up)
               || (timed && (wd_cnt == WD_LAST));
    served = '0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (stop_next)
        served[i] = (i == int'(next_floor));
      else if ((state == ST_IDLE) || (state == ST_OPENING) || (state == ST_DWELL))
        served[i] = (i == int'(floor));
    end
    next_pending = (pending | buttons) & ~served;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      engine    <= ENG_STOP;
      door      <= DOOR_HOLD;
      floor     <= '0;
      pending   <= '0;
      fault     <= 1'b0;
      dir_up    <= 1'b1;
      dwell_cnt <= '0;
      wd_cnt    <= '0;
    end else if ((state == ST_FAULT) || fault_now) begin
      state  <= ST_FAULT;
      engine <= ENG_STOP;
      door   <= DOOR_OPEN;
      fault  <= 1'b1;
    end else begin
      pending <= next_pending;
      wd_cnt  <= timed ? wd_cnt + WD_W'(1) : '0;
      case (state)
        ST_IDLE: begin
          door <= DOOR_HOLD;
          if (req_here || buttons[floor]) begin
            state <= ST_OPENING;
            door  <= DOOR_OPEN;
          end else if (req_above || req_below) begin
            state <= ST_CLOSING;
            door  <= DOOR_CLOSE;
          end
        end
        ST_CLOSING: begin
          if (sensor_door == SD_CLOSED) begin
            wd_cnt <= '0;
            door   <= DOOR_HOLD;
            if (go_up) begin
              state  <= ST_MOVE_UP;
              engine <= ENG_UP;
              dir_up <= 1'b1;
            end else if (req_below) begin
              state  <= ST_MOVE_DOWN;
              engine <= ENG_DOWN;
              dir_up <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            door <= DOOR_CLOSE;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          door <= DOOR_HOLD;
          if (floor_pulse) begin
            floor  <= next_floor;
            wd_cnt <= '0;
            if (stop_next) begin
              state  <= ST_OPENING;
              engine <= ENG_STOP;
            end
          end
        end
        ST_OPENING: begin
          if (sensor_door == SD_OPEN) begin
            state     <= ST_DWELL;
            door      <= DOOR_HOLD;
            dwell_cnt <= '0;
            wd_cnt    <= '0;
          end else begin
            door <= DOOR_OPEN;
          end
        end
        ST_DWELL: begin
          if (buttons[floor]) begin
            dwell_cnt <= '0;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (req_above || req_below) begin
              state <= ST_CLOSING;
              door  <= DOOR_CLOSE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed vector table plus corner-case sequences for elevator_ctrl
module tb_elevator_ctrl;
  import elevator_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] buttons;
  logic [1:0] sensor_door;
  logic       sensor_up, sensor_down;
  logic [1:0] engine, door;
  logic [2:0] floor;
  logic [7:0] pending;
  logic       fault;

  typedef struct {
    logic       rst;
    logic [7:0] btn;
    logic [1:0] sd;
    logic       up;
    logic       dn;
    int         rep;
    logic [1:0] eng;
    logic [1:0] dr;
    logic [2:0] fl;
    logic [7:0] pend;
    logic       flt;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  elevator_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .buttons    (buttons),
    .sensor_door(sensor_door),
    .sensor_up  (sensor_up),
    .sensor_down(sensor_down),
    .engine     (engine),
    .door       (door),
    .floor      (floor),
    .pending    (pending),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic [7:0] btn, input logic [1:0] sd,
                     input logic up, input logic dn, input int rep,
                     input logic [1:0] eng, input logic [1:0] dr, input logic [2:0] fl,
                     input logic [7:0] pend, input logic flt);
    vec_t v;
    v.rst = rst; v.btn = btn; v.sd = sd; v.up = up; v.dn = dn; v.rep = rep;
    v.eng = eng; v.dr = dr; v.fl = fl; v.pend = pend; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] eng, input logic [1:0] dr,
                            input logic [2:0] fl, input logic [7:0] pend, input logic flt);
    chk($sformatf("%s.engine", tag), 8'(engine), 8'(eng));
    chk($sformatf("%s.door", tag), 8'(door), 8'(dr));
    chk($sformatf("%s.floor", tag), 8'(floor), 8'(fl));
    chk($sformatf("%s.pending", tag), pending, pend);
    chk($sformatf("%s.fault", tag), 8'(fault), 8'(flt));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cyc(input logic rst, input logic [7:0] btn, input logic [1:0] sd,
                     input logic up, input logic dn, input int n);
    reset = rst; buttons = btn; sensor_door = sd; sensor_up = up; sensor_down = dn;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic go_to_move_up(input logic [7:0] call);
    cyc(1, 8'h00, SD_CLOSED, 0, 0, 2);
    cyc(0, call, SD_CLOSED, 0, 0, 1);
    cyc(0, 8'h00, SD_CLOSED, 0, 0, 1);
    cyc(0, 8'h00, SD_CLOSED, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; buttons = '0; sensor_door = SD_OPEN; sensor_up = 0; sensor_down = 0;

    // Trip to floor 3: close, climb three floors, open, dwell, idle.
    add(1, 8'h00, SD_OPEN,    0, 0, 2,  ENG_STOP, DOOR_HOLD,  0, 8'h00, 0);
    add(0, 8'h08, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  0, 8'h08, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_CLOSE, 0, 8'h08, 0);
    add(0, 8'h00, SD_TRANSIT, 0, 0, 5,  ENG_STOP, DOOR_CLOSE, 0, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_UP,   DOOR_HOLD,  0, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 3,  ENG_UP,   DOOR_HOLD,  0, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  1, 0, 1,  ENG_UP,   DOOR_HOLD,  1, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 2,  ENG_UP,   DOOR_HOLD,  1, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  1, 0, 1,  ENG_UP,   DOOR_HOLD,  2, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_UP,   DOOR_HOLD,  2, 8'h08, 0);
    add(0, 8'h00, SD_CLOSED,  1, 0, 1,  ENG_STOP, DOOR_HOLD,  3, 8'h00, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_STOP, DOOR_OPEN,  3, 8'h00, 0);
    add(0, 8'h00, SD_TRANSIT, 0, 0, 3,  ENG_STOP, DOOR_OPEN,  3, 8'h00, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  3, 8'h00, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 19, ENG_STOP, DOOR_HOLD,  3, 8'h00, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  3, 8'h00, 0);
    // SCAN from floor 3 with calls at 6 and 0; a press for 6 while stopping at 6 stays clear.
    add(0, 8'h41, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  3, 8'h41, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_CLOSE, 3, 8'h41, 0);
    add(0, 8'h00, SD_TRANSIT, 0, 0, 2,  ENG_STOP, DOOR_CLOSE, 3, 8'h41, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_UP,   DOOR_HOLD,  3, 8'h41, 0);
    add(0, 8'h00, SD_CLOSED,  1, 0, 1,  ENG_UP,   DOOR_HOLD,  4, 8'h41, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_UP,   DOOR_HOLD,  4, 8'h41, 0);
    add(0, 8'h00, SD_CLOSED,  1, 0, 1,  ENG_UP,   DOOR_HOLD,  5, 8'h41, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_UP,   DOOR_HOLD,  5, 8'h41, 0);
    add(0, 8'h40, SD_CLOSED,  1, 0, 1,  ENG_STOP, DOOR_HOLD,  6, 8'h01, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_STOP, DOOR_OPEN,  6, 8'h01, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  6, 8'h01, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 19, ENG_STOP, DOOR_HOLD,  6, 8'h01, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_CLOSE, 6, 8'h01, 0);
    add(0, 8'h00, SD_TRANSIT, 0, 0, 1,  ENG_STOP, DOOR_CLOSE, 6, 8'h01, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_DOWN, DOOR_HOLD,  6, 8'h01, 0);
    for (int f = 5; f >= 1; f--) begin
      add(0, 8'h00, SD_CLOSED, 0, 1, 1, ENG_DOWN, DOOR_HOLD, 3'(f), 8'h01, 0);
      add(0, 8'h00, SD_CLOSED, 0, 0, 1, ENG_DOWN, DOOR_HOLD, 3'(f), 8'h01, 0);
    end
    add(0, 8'h00, SD_CLOSED,  0, 1, 1,  ENG_STOP, DOOR_HOLD,  0, 8'h00, 0);
    add(0, 8'h00, SD_CLOSED,  0, 0, 1,  ENG_STOP, DOOR_OPEN,  0, 8'h00, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 1,  ENG_STOP, DOOR_HOLD,  0, 8'h00, 0);
    add(0, 8'h00, SD_OPEN,    0, 0, 20, ENG_STOP, DOOR_HOLD,  0, 8'h00, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].btn, vecs[i].sd, vecs[i].up, vecs[i].dn, vecs[i].rep);
      expect_out($sformatf("vec%0d", i), vecs[i].eng, vecs[i].dr, vecs[i].fl, vecs[i].pend, vecs[i].flt);
    end

    // Current-floor press at dwell cycle 10 restarts the 20-cycle dwell.
    cyc(0, 8'h01, SD_OPEN, 0, 0, 1);
    expect_out("here_open", ENG_STOP, DOOR_OPEN, 0, 8'h00, 0);
    cyc(0, 8'h00, SD_OPEN, 0, 0, 1);
    cyc(0, 8'h02, SD_OPEN, 0, 0, 1);
    cyc(0, 8'h00, SD_OPEN, 0, 0, 8);
    cyc(0, 8'h01, SD_OPEN, 0, 0, 1);
    expect_out("restart", ENG_STOP, DOOR_HOLD, 0, 8'h02, 0);
    for (int k = 0; k < 19; k++) begin
      cyc(0, 8'h00, SD_OPEN, 0, 0, 1);
      chk($sformatf("restart.door%0d", k), 8'(door), 8'(DOOR_HOLD));
    end
    cyc(0, 8'h00, SD_OPEN, 0, 0, 1);
    expect_out("restart_end", ENG_STOP, DOOR_CLOSE, 0, 8'h02, 0);

    // Door stuck in transit while closing trips the watchdog on cycle 64.
    cyc(1, 8'h00, SD_TRANSIT, 0, 0, 2);
    expect_out("wd_reset", ENG_STOP, DOOR_HOLD, 0, 8'h00, 0);
    cyc(0, 8'h04, SD_TRANSIT, 0, 0, 1);
    cyc(0, 8'h00, SD_TRANSIT, 0, 0, 1);
    cyc(0, 8'h00, SD_TRANSIT, 0, 0, 63);
    expect_out("wd_63", ENG_STOP, DOOR_CLOSE, 0, 8'h04, 0);
    cyc(0, 8'h00, SD_TRANSIT, 0, 0, 1);
    expect_out("wd_64", ENG_STOP, DOOR_OPEN, 0, 8'h04, 1);
    cyc(0, 8'h80, SD_CLOSED, 0, 0, 5);
    expect_out("wd_sticky", ENG_STOP, DOOR_OPEN, 0, 8'h04, 1);

    // Up pulse while parked at the top floor.
    go_to_move_up(8'h80);
    expect_out("top_move", ENG_UP, DOOR_HOLD, 0, 8'h80, 0);
    for (int f = 1; f <= 7; f++) cyc(0, 8'h00, SD_CLOSED, 1, 0, 1);
    expect_out("top_stop", ENG_STOP, DOOR_HOLD, 7, 8'h00, 0);
    cyc(0, 8'h00, SD_CLOSED, 1, 0, 1);
    expect_out("top_fault", ENG_STOP, DOOR_OPEN, 7, 8'h00, 1);

    // Invalid door sensor code from idle.
    cyc(1, 8'h00, SD_CLOSED, 0, 0, 2);
    cyc(0, 8'h00, SD_INVALID, 0, 0, 1);
    expect_out("sd_invalid", ENG_STOP, DOOR_OPEN, 0, 8'h00, 1);

    // Opposite-direction pulse while moving up.
    go_to_move_up(8'h10);
    cyc(0, 8'h00, SD_CLOSED, 0, 1, 1);
    expect_out("opposite", ENG_STOP, DOOR_OPEN, 0, 8'h10, 1);

    // Reset mid-move at floor 4 aborts and does not resume.
    go_to_move_up(8'h20);
    for (int f = 1; f <= 4; f++) cyc(0, 8'h00, SD_CLOSED, 1, 0, 1);
    expect_out("mid_move", ENG_UP, DOOR_HOLD, 4, 8'h20, 0);
    cyc(1, 8'h00, SD_CLOSED, 0, 0, 1);
    expect_out("mid_reset", ENG_STOP, DOOR_HOLD, 0, 8'h00, 0);
    cyc(0, 8'h00, SD_CLOSED, 0, 0, 3);
    expect_out("after_reset", ENG_STOP, DOOR_HOLD, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
